// File: rtl/sim_pkg.sv
// Shared definitions for the query scheduler and the similarity datapath:
// the scheduler FSM state encoding and the width helpers for counts,
// scores, segment indices and class indices.
package sim_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_READ     = 3'd1,
      ST_WAIT_RD  = 3'd2,
      ST_WAIT_SIM = 3'd3,
      ST_CMP      = 3'd4,
      ST_DONE     = 3'd5
   } sim_state_t;

   // Width of an index into n items; a single item still needs one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a count that can reach n inclusive.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   localparam int LENGTH_SEGMENT_DFLT = 32;
   localparam int NB_OF_SEGMENTS_DFLT = 32;
   localparam int NB_CLASSES_DFLT     = 16;
   localparam int D_DFLT              = LENGTH_SEGMENT_DFLT * NB_OF_SEGMENTS_DFLT;

   localparam int COUNT_W = cnt_w(LENGTH_SEGMENT_DFLT);
   localparam int SCORE_W = cnt_w(D_DFLT);
   localparam int SGMNT_W = idx_w(NB_OF_SEGMENTS_DFLT);
   localparam int CLASS_W = idx_w(NB_CLASSES_DFLT);

endpackage

// File: rtl/sim_argmax.sv
// Running argmax over class scores. On an update strobe the candidate is
// loaded if it is the first class of a query (clr) or strictly beats the
// held best, so ties keep the lower class index.
module sim_argmax #(
   parameter int SCORE_W = 11,
   parameter int CLASS_W = 4
) (
   input  logic               clk,
   input  logic               arst_n_in,
   input  logic               upd,
   input  logic               clr,
   input  logic [SCORE_W-1:0] score,
   input  logic [CLASS_W-1:0] class_idx,
   output logic [SCORE_W-1:0] best_score,
   output logic [CLASS_W-1:0] best_class
);

   logic [SCORE_W-1:0] best_score_reg;
   logic [CLASS_W-1:0] best_class_reg;

   // Capture the candidate when it opens a query or strictly exceeds the best so far.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         best_score_reg <= '0;
         best_class_reg <= '0;
      end else if (upd && (clr || (score > best_score_reg))) begin
         best_score_reg <= score;
         best_class_reg <= class_idx;
      end
   end

   assign best_score = best_score_reg;
   assign best_class = best_class_reg;

endmodule

// File: rtl/sim_query_scheduler.sv
// Classifies one query hypervector against NB_CLASSES stored classes by
// walking every (class, segment) pair through a single similarity unit,
// accumulating a per-class score and keeping the best class.
module sim_query_scheduler
   import sim_pkg::*;
#(
   parameter int D              = 1024,
   parameter int LENGTH_SEGMENT = 32,
   parameter int NB_OF_SEGMENTS = 32,
   parameter int NB_CLASSES     = 16
) (
   input  logic                                clk,
   input  logic                                arst_n_in,
   input  logic                                start_query,
   output logic                                busy,
   output logic                                rd_en,
   output logic [idx_w(NB_CLASSES)-1:0]        rd_class,
   output logic [idx_w(NB_OF_SEGMENTS)-1:0]    rd_sgmnt,
   input  logic                                rd_valid,
   output logic                                sim_start,
   input  logic                                sim_done,
   input  logic [cnt_w(LENGTH_SEGMENT)-1:0]    sim_count,
   output logic                                done,
   output logic [idx_w(NB_CLASSES)-1:0]        best_class,
   output logic [cnt_w(D)-1:0]                 best_score
);

   localparam int CLS_W = idx_w(NB_CLASSES);
   localparam int SEG_W = idx_w(NB_OF_SEGMENTS);
   localparam int SCR_W = cnt_w(D);
   localparam logic [SEG_W-1:0] LAST_SGMNT = SEG_W'(NB_OF_SEGMENTS - 1);
   localparam logic [CLS_W-1:0] LAST_CLASS = CLS_W'(NB_CLASSES - 1);

   // Reject inconsistent geometry at elaboration.
   generate
      if (D != LENGTH_SEGMENT * NB_OF_SEGMENTS) begin : g_bad_geometry
         $error("sim_query_scheduler: D must equal LENGTH_SEGMENT*NB_OF_SEGMENTS");
      end
      if (NB_CLASSES < 1) begin : g_bad_classes
         $error("sim_query_scheduler: NB_CLASSES must be at least 1");
      end
   endgenerate

   sim_state_t         state_reg, state_next;
   logic [SEG_W-1:0]   sgmnt_reg, sgmnt_next;
   logic [CLS_W-1:0]   class_reg, class_next;
   logic [SCR_W-1:0]   score_reg, score_next;
   logic               argmax_upd;

   // State, counters and score accumulator.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state_reg <= ST_IDLE;
         sgmnt_reg <= '0;
         class_reg <= '0;
         score_reg <= '0;
      end else begin
         state_reg <= state_next;
         sgmnt_reg <= sgmnt_next;
         class_reg <= class_next;
         score_reg <= score_next;
      end
   end

   // Next-state, counter updates and handshake outputs.
   always_comb begin
      state_next = state_reg;
      sgmnt_next = sgmnt_reg;
      class_next = class_reg;
      score_next = score_reg;
      busy       = 1'b1;
      rd_en      = 1'b0;
      sim_start  = 1'b0;
      done       = 1'b0;
      argmax_upd = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            busy = 1'b0;
            if (start_query) begin
               sgmnt_next = '0;
               class_next = '0;
               score_next = '0;
               state_next = ST_READ;
            end
         end
         ST_READ: begin
            rd_en      = 1'b1;
            state_next = ST_WAIT_RD;
         end
         ST_WAIT_RD: begin
            if (rd_valid) begin
               sim_start  = 1'b1;
               state_next = ST_WAIT_SIM;
            end
         end
         ST_WAIT_SIM: begin
            if (sim_done) begin
               score_next = score_reg + SCR_W'(sim_count);
               if (sgmnt_reg == LAST_SGMNT) begin
                  state_next = ST_CMP;
               end else begin
                  sgmnt_next = sgmnt_reg + 1'b1;
                  state_next = ST_READ;
               end
            end
         end
         ST_CMP: begin
            argmax_upd = 1'b1;
            if (class_reg == LAST_CLASS) begin
               state_next = ST_DONE;
            end else begin
               class_next = class_reg + 1'b1;
               sgmnt_next = '0;
               score_next = '0;
               state_next = ST_READ;
            end
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = ST_IDLE;
         end
      endcase
   end

   assign rd_class = class_reg;
   assign rd_sgmnt = sgmnt_reg;

   sim_argmax #(
      .SCORE_W (SCR_W),
      .CLASS_W (CLS_W)
   ) u_argmax (
      .clk        (clk),
      .arst_n_in  (arst_n_in),
      .upd        (argmax_upd),
      .clr        (class_reg == '0),
      .score      (score_reg),
      .class_idx  (class_reg),
      .best_score (best_score),
      .best_class (best_class)
   );

endmodule

// File: tb/tb_sim_query_scheduler.sv
// Directed bench for sim_query_scheduler (D=8, 4-bit segments, 2 segments,
// 3 classes) plus a single-class instance. A responder models the item
// memory and similarity unit with optional random stalls and spurious pulses.
module tb_sim_query_scheduler;

   logic       clk = 1'b0;
   logic       arst_n_in;
   logic       start_query;
   logic       busy, rd_en, rd_valid, sim_start, sim_done, done;
   logic [1:0] rd_class, best_class;
   logic [0:0] rd_sgmnt;
   logic [2:0] sim_count;
   logic [3:0] best_score;

   logic       start1, busy1, rd_en1, rd_valid1, sim_start1, sim_done1, done1;
   logic [0:0] rd_class1, rd_sgmnt1, best_class1;
   logic [2:0] sim_count1;
   logic [3:0] best_score1;

   int checks   = 0;
   int failures = 0;
   int counts[6];
   bit stall_mode = 0;
   bit hold_c1    = 0;
   bit in_hold    = 0;
   bit hold_start = 0;
   int rd_n = 0, ss_n = 0, bad_ss = 0, done_n = 0;
   int rd_log[256];

   always #5 clk = ~clk;

   sim_query_scheduler #(.D(8), .LENGTH_SEGMENT(4), .NB_OF_SEGMENTS(2), .NB_CLASSES(3)) dut (
      .clk(clk), .arst_n_in(arst_n_in), .start_query(start_query), .busy(busy),
      .rd_en(rd_en), .rd_class(rd_class), .rd_sgmnt(rd_sgmnt), .rd_valid(rd_valid),
      .sim_start(sim_start), .sim_done(sim_done), .sim_count(sim_count), .done(done),
      .best_class(best_class), .best_score(best_score)
   );

   sim_query_scheduler #(.D(8), .LENGTH_SEGMENT(4), .NB_OF_SEGMENTS(2), .NB_CLASSES(1)) dut1 (
      .clk(clk), .arst_n_in(arst_n_in), .start_query(start1), .busy(busy1),
      .rd_en(rd_en1), .rd_class(rd_class1), .rd_sgmnt(rd_sgmnt1), .rd_valid(rd_valid1),
      .sim_start(sim_start1), .sim_done(sim_done1), .sim_count(sim_count1), .done(done1),
      .best_class(best_class1), .best_score(best_score1)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Memory + similarity model for one segment pair, entered in the READ cycle.
   task automatic serve();
      int c, s, d;
      c = int'(rd_class);
      s = int'(rd_sgmnt);
      rd_valid  = stall_mode;       // spurious pulses in READ must be ignored
      sim_done  = stall_mode;
      sim_count = 3'd3;
      @(posedge clk); #1;
      rd_valid = 1'b0;
      sim_done = 1'b0;
      d = stall_mode ? int'($urandom_range(0, 5)) : 0;
      repeat (d) begin @(posedge clk); #1; end
      rd_valid = 1'b1;
      @(posedge clk); #1;
      rd_valid = 1'b0;
      if (hold_c1 && c == 1) begin
         in_hold = 1'b1;
         wait (!arst_n_in);
         wait (arst_n_in);
         @(posedge clk); #1;
      end
      d = stall_mode ? int'($urandom_range(0, 5)) : 0;
      repeat (d) begin @(posedge clk); #1; end
      sim_done  = 1'b1;
      sim_count = 3'(counts[c*2 + s]);
      @(posedge clk); #1;
      sim_done = 1'b0;
      in_hold  = 1'b0;
   endtask

   // Responder for the main instance.
   initial begin
      rd_valid = 1'b0; sim_done = 1'b0; sim_count = '0;
      @(posedge clk); #1;
      forever begin
         if (rd_en) begin
            serve();
         end else begin
            if (stall_mode && $urandom_range(0, 2) == 0) begin
               rd_valid = 1'b1; sim_done = 1'b1; sim_count = 3'd3;
            end else begin
               rd_valid = 1'b0; sim_done = 1'b0;
            end
            @(posedge clk); #1;
         end
      end
   end

   // Zero-wait responder for the single-class instance; every count is 0.
   initial begin
      logic nrv, nsd;
      rd_valid1 = 1'b0; sim_done1 = 1'b0; sim_count1 = '0;
      forever begin
         @(negedge clk);
         nrv = rd_en1;
         nsd = sim_start1;
         @(posedge clk); #1;
         rd_valid1 = nrv;
         sim_done1 = nsd;
      end
   end

   // Activity monitor, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (rd_en) begin
            if (rd_n < 256) rd_log[rd_n] = int'(rd_class) * 16 + int'(rd_sgmnt);
            rd_n++;
         end
         if (sim_start) begin
            ss_n++;
            if (!rd_valid) bad_ss++;
         end
         if (done) done_n++;
      end
   end

   // Counts cycles from the current cycle until done; -1 on timeout.
   task automatic wait_done(input int max_cyc, output int lat);
      lat = -1;
      for (int k = 1; k <= max_cyc; k++) begin
         @(posedge clk); #1;
         start_query = hold_start;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run_query(input string tag, input int exp_cls, input int exp_scr, input int exp_lat);
      int lat;
      @(posedge clk); #1;
      start_query = 1'b1;
      wait_done(400, lat);
      if (exp_lat >= 0) check_eq({tag, "_latency"}, lat, exp_lat);
      else              check_eq({tag, "_done_seen"}, 32'(lat > 0), 1);
      check_eq({tag, "_busy_in_done"}, busy, 1);
      check_eq({tag, "_best_class"}, best_class, exp_cls);
      check_eq({tag, "_best_score"}, best_score, exp_scr);
      @(posedge clk); #1;
      check_eq({tag, "_done_one_cycle"}, done, 0);
      $display("query %s: latency=%0d best_class=%0d best_score=%0d", tag, lat, best_class, best_score);
   endtask

   initial begin
      int n0, s0, b0, d0, lat;
      start_query = 1'b0;
      start1      = 1'b0;
      arst_n_in   = 1'b0;

      // Reset state
      repeat (2) @(posedge clk); #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_rd_en", rd_en, 0);
      check_eq("rst_sim_start", sim_start, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_rd_class", rd_class, 0);
      check_eq("rst_rd_sgmnt", rd_sgmnt, 0);
      check_eq("rst_best_class", best_class, 0);
      check_eq("rst_best_score", best_score, 0);
      arst_n_in = 1'b1;
      n0 = rd_n;
      repeat (6) begin @(posedge clk); #1; end
      check_eq("idle_rd_en_count", rd_n - n0, 0);
      check_eq("idle_busy", busy, 0);

      // Basic argmax: scores 3, 7, 4
      counts = '{1, 2, 4, 3, 2, 2};
      n0 = rd_n;
      run_query("basic", 1, 7, 22);
      check_eq("basic_rd_count", rd_n - n0, 6);
      for (int k = 0; k < 6; k++)
         check_eq($sformatf("basic_rd_seq%0d", k), rd_log[n0 + k], (k / 2) * 16 + (k % 2));

      // Tie: scores 5, 5, 3
      counts = '{2, 3, 5, 0, 1, 2};
      run_query("tie", 0, 5, 22);

      // Single class, all-zero counts
      @(posedge clk); #1;
      start1 = 1'b1;
      lat = -1;
      for (int k = 1; k <= 50; k++) begin
         @(posedge clk); #1;
         start1 = 1'b0;
         if (done1) begin lat = k; break; end
      end
      check_eq("one_class_latency", lat, 8);
      check_eq("one_class_best_class", best_class1, 0);
      check_eq("one_class_best_score", best_score1, 0);
      $display("query one_class: latency=%0d", lat);

      // Random stalls and spurious pulses
      counts = '{1, 2, 4, 3, 2, 2};
      stall_mode = 1'b1;
      n0 = rd_n; s0 = ss_n; b0 = bad_ss;
      run_query("stall", 1, 7, -1);
      stall_mode = 1'b0;
      check_eq("stall_sim_start_count", ss_n - s0, 6);
      check_eq("stall_sim_start_wo_rd_valid", bad_ss - b0, 0);
      check_eq("stall_rd_count", rd_n - n0, 6);

      // start_query held high: back-to-back queries, one done each
      counts = '{4, 4, 4, 4, 4, 4};
      repeat (3) begin @(posedge clk); #1; end
      d0 = done_n;
      hold_start  = 1'b1;
      start_query = 1'b1;
      wait_done(400, lat);
      check_eq("held_latency", lat, 22);
      check_eq("held_best_score", best_score, 8);
      check_eq("held_best_class", best_class, 0);
      @(posedge clk); #1;
      check_eq("held_idle_busy", busy, 0);
      @(posedge clk); #1;
      check_eq("held_b2b_accept", busy, 1);
      wait_done(400, lat);
      hold_start  = 1'b0;
      start_query = 1'b0;
      check_eq("held_second_latency", lat, 21);
      repeat (4) begin @(posedge clk); #1; end
      check_eq("held_done_count", done_n - d0, 2);
      check_eq("held_end_busy", busy, 0);
      $display("query held: two back-to-back queries, done pulses=%0d", done_n - d0);

      // Mid-query reset in WAIT_SIM of class 1
      counts  = '{1, 2, 4, 3, 2, 2};
      hold_c1 = 1'b1;
      d0 = done_n;
      @(posedge clk); #1;
      start_query = 1'b1;
      @(posedge clk); #1;
      start_query = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (in_hold) break;
         @(posedge clk); #1;
      end
      check_eq("midrst_reached_hold", in_hold, 1);
      @(posedge clk); #1;
      check_eq("midrst_pre_rd_class", rd_class, 1);
      check_eq("midrst_pre_best_score", best_score, 3);
      #2;
      arst_n_in = 1'b0;
      #1;
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_rd_class", rd_class, 0);
      check_eq("midrst_best_score", best_score, 0);
      check_eq("midrst_best_class", best_class, 0);
      #2;
      arst_n_in = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      check_eq("midrst_late_sim_done_busy", busy, 0);
      check_eq("midrst_no_done", done_n - d0, 0);
      hold_c1 = 1'b0;
      run_query("after_reset", 1, 7, 22);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got time limit expected completion");
      $fatal(1, "timeout");
   end

endmodule
